// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M execution unit for the EX stage.
// Multiplies go through a MUL_LAT-cycle product path. Divides run a
// 32-iteration restoring divider. The pipeline is stalled until the result
// is ready. Divide-by-zero and signed overflow return the RV32M values.
module muldiv_seq #(
  parameter int MUL_LAT  = 2,
  parameter bit DIV_FAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LAST = 6'd31;

  state_e      state_q, state_d;
  logic [1:0]  funct3_q, funct3_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] quo_q, quo_d;
  logic [32:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;

  // Divide by zero, or the one signed quotient that does not fit in 32 bits.
  // f3[0]=0 marks the signed divide ops (DIV, REM).
  function automatic logic is_special(input logic [1:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
    return (b == 32'd0) || (!f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  // RV32M results for the special cases; f3[1]=1 selects the remainder.
  function automatic logic [31:0] special_result(input logic [1:0] f3, input logic [31:0] a,
                                                 input logic [31:0] b);
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    return f3[1] ? 32'd0 : 32'h8000_0000;
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

  // Product path. Operands are sign- or zero-extended to 64 bits; the low
  // 64 bits of the product are then correct for every signedness combination.
  logic        a_sgn, b_sgn;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] mul_res;
  always_comb begin
    a_sgn   = (funct3_q != 2'b11) & a_q[31];
    b_sgn   = ~funct3_q[1] & b_q[31];
    a_ext   = {{32{a_sgn}}, a_q};
    b_ext   = {{32{b_sgn}}, b_q};
    prod    = a_ext * b_ext;
    mul_res = (funct3_q == 2'b00) ? prod[31:0] : prod[63:32];
  end

  // One restoring-divide step on magnitudes, plus the sign fix and special
  // override applied when the last step retires.
  logic [33:0] shifted, diff;
  logic        q_bit, div_sgn, neg_q, neg_r;
  logic [32:0] rem_next;
  logic [31:0] quo_next, div_res;
  always_comb begin
    shifted  = {rem_q, quo_q[31]};
    diff     = shifted - {2'b00, dvsr_q};
    q_bit    = ~diff[33];
    rem_next = q_bit ? diff[32:0] : shifted[32:0];
    quo_next = {quo_q[30:0], q_bit};
    div_sgn  = ~funct3_q[0];
    neg_q    = div_sgn & (a_q[31] ^ b_q[31]);
    neg_r    = div_sgn & a_q[31];
    if (funct3_q[1]) div_res = neg_r ? -rem_next[31:0] : rem_next[31:0];
    else             div_res = neg_q ? -quo_next : quo_next;
    if (is_special(funct3_q, a_q, b_q)) div_res = special_result(funct3_q, a_q, b_q);
  end

  // Next-state, datapath loads and handshake outputs.
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    a_d      = a_q;
    b_d      = b_q;
    dvsr_d   = dvsr_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    stall    = 1'b0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        stall = start;
        if (start && !flush) begin
          funct3_d = funct3[1:0];
          a_d      = rs1;
          b_d      = rs2;
          cnt_d    = 6'd0;
          if (!funct3[2]) begin
            state_d = S_MUL;
          end else if (DIV_FAST && is_special(funct3[1:0], rs1, rs2)) begin
            state_d  = S_DONE;
            result_d = special_result(funct3[1:0], rs1, rs2);
          end else begin
            state_d = S_DIV;
            quo_d   = mag(rs1, ~funct3[0]);
            dvsr_d  = mag(rs2, ~funct3[0]);
            rem_d   = 33'd0;
          end
        end
      end
      S_MUL: begin
        stall = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end else if (cnt_q == MUL_LAST) begin
          state_d  = S_DONE;
          result_d = mul_res;
          cnt_d    = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DIV: begin
        stall = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end else begin
          rem_d = rem_next;
          quo_d = quo_next;
          if (cnt_q == DIV_LAST) begin
            state_d  = S_DONE;
            result_d = div_res;
            cnt_d    = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      funct3_q <= 2'b00;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      dvsr_q   <= 32'd0;
      quo_q    <= 32'd0;
      rem_q    <= 33'd0;
      cnt_q    <= 6'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dvsr_q   <= dvsr_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq. Two instances are
// built: one with the fast special-case path and one without.
module tb_muldiv_seq;

  localparam int MUL_LAT = 2;
  localparam int LAT_MUL = MUL_LAT + 1;
  localparam int LAT_DIV = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_f, start_s, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        stall_f, done_f, busy_f;
  logic        stall_s, done_s, busy_s;
  logic [31:0] result_f, result_s;

  bit sel;
  wire        v_stall  = sel ? stall_s  : stall_f;
  wire        v_done   = sel ? done_s   : done_f;
  wire        v_busy   = sel ? busy_s   : busy_f;
  wire [31:0] v_result = sel ? result_s : result_f;

  muldiv_seq #(.MUL_LAT(MUL_LAT), .DIV_FAST(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start_f), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .flush(flush), .stall(stall_f), .done(done_f), .result(result_f), .busy(busy_f)
  );

  muldiv_seq #(.MUL_LAT(MUL_LAT), .DIV_FAST(1'b0)) dut_slow (
    .clk(clk), .rst(rst), .start(start_s), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .flush(flush), .stall(stall_s), .done(done_s), .result(result_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_res = 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic setStart(input logic v);
    if (sel) start_s = v;
    else     start_f = v;
  endtask

  // Called at a falling edge: drives one instruction and records its expectation.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input int lat);
    exp_t e;
    e.res = res;
    e.lat = lat;
    sb.push_back(e);
    funct3 = f3;
    rs1    = a;
    rs2    = b;
    setStart(1'b1);
    #1 checkOutput("stall_on_accept", {31'd0, v_stall}, 32'd1);
  endtask

  // Waits for done (bounded), pops the scoreboard and checks value and latency.
  // With poke set, a different instruction is offered while the unit is busy.
  task automatic waitDone(input string name, input bit poke);
    exp_t e;
    bit   seen = 1'b0;
    int   k;
    @(negedge clk);
    setStart(1'b0);
    for (k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clk);
      if (poke && k == 1) begin
        funct3 = 3'b100;
        rs1    = $urandom;
        rs2    = $urandom;
        setStart(1'b1);
      end
      if (poke && k == 2) setStart(1'b0);
      #1;
      if (v_done) begin
        seen = 1'b1;
        break;
      end
      checkOutput({name, " stall_busy"}, {30'd0, v_stall, v_busy}, 32'd3);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s timeout: no done after %0d cycles", name, k);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    checkOutput({name, " result"}, v_result, e.res);
    checkOutput({name, " latency"}, k, e.lat);
    checkOutput({name, " done_flags"}, {30'd0, v_stall, v_busy}, 32'd1);
    last_res = e.res;
    @(negedge clk);
    #1 checkOutput({name, " after_done"}, {30'd0, v_done, v_busy}, 32'd0);
  endtask

  vec_t fast_vecs[$];
  vec_t slow_vecs[$];

  initial begin
    // {funct3, rs1, rs2, expected result, expected latency}
    fast_vecs = '{
      '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_MUL},
      '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_MUL},
      '{3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_MUL},
      '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT_MUL},
      '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_MUL},
      '{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, LAT_MUL},
      '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, LAT_DIV},
      '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, LAT_DIV},
      '{3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, LAT_DIV},
      '{3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, LAT_DIV},
      '{3'b100, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, LAT_DIV},
      '{3'b110, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, LAT_DIV},
      '{3'b101, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1},
      '{3'b111, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1},
      '{3'b100, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 1},
      '{3'b110, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 1},
      '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
      '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1},
      '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_DIV},
      '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_DIV}
    };
    slow_vecs = '{
      '{3'b101, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, LAT_DIV},
      '{3'b111, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, LAT_DIV},
      '{3'b100, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, LAT_DIV},
      '{3'b110, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, LAT_DIV},
      '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_DIV},
      '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_DIV}
    };

    sel     = 1'b0;
    rst     = 1'b1;
    start_f = 1'b0;
    start_s = 1'b0;
    flush   = 1'b0;
    funct3  = 3'b000;
    rs1     = 32'd0;
    rs2     = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset fast", {stall_f, done_f, busy_f, result_f}, 35'd0);
    checkOutput("reset slow", {stall_s, done_s, busy_s, result_s}, 35'd0);

    $display("[TB] table vectors, fast special path");
    foreach (fast_vecs[i]) begin
      @(negedge clk);
      applyStimulus(fast_vecs[i].f3, fast_vecs[i].a, fast_vecs[i].b,
                    fast_vecs[i].res, fast_vecs[i].lat);
      waitDone($sformatf("vec%0d", i), 1'b0);
    end

    $display("[TB] start while busy is ignored");
    @(negedge clk);
    applyStimulus(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_MUL);
    waitDone("poke_mul", 1'b1);

    $display("[TB] flush and start together in idle");
    @(negedge clk);
    funct3  = 3'b000;
    rs1     = 32'd3;
    rs2     = 32'd5;
    start_f = 1'b1;
    flush   = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    flush   = 1'b0;
    #1 checkOutput("flush_start busy", {31'd0, busy_f}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      #1 checkOutput("flush_start no_done", {31'd0, done_f}, 32'd0);
    end
    checkOutput("flush_start result", result_f, last_res);

    $display("[TB] flush in the middle of a divide");
    @(negedge clk);
    funct3  = 3'b100;
    rs1     = 32'h0000_0064;
    rs2     = 32'h0000_0007;
    start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 10) flush = 1'b1;
      #1 checkOutput("flush_div running", {30'd0, done_f, busy_f}, 32'd1);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("flush_div idle", {stall_f, done_f, busy_f}, 3'd0);
    checkOutput("flush_div result", result_f, last_res);
    applyStimulus(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_MUL);
    waitDone("after_flush", 1'b0);

    $display("[TB] reset in the middle of a divide");
    @(negedge clk);
    funct3  = 3'b101;
    rs1     = 32'h0000_1000;
    rs2     = 32'h0000_0003;
    start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("rst_mid_op", {stall_f, done_f, busy_f, result_f}, 35'd0);

    $display("[TB] table vectors, full-length special cases");
    sel = 1'b1;
    foreach (slow_vecs[i]) begin
      @(negedge clk);
      applyStimulus(slow_vecs[i].f3, slow_vecs[i].a, slow_vecs[i].b,
                    slow_vecs[i].res, slow_vecs[i].lat);
      waitDone($sformatf("slow%0d", i), 1'b0);
    end

    checkOutput("scoreboard empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
